// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_pkg
// Purpose  : Shared types and defaults for the sequential restoring divider.
//            Holds the controller state encoding and the default operand width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/seq_divider_trial_sub.sv
`default_nettype none
// ============================================================================
// Module   : div_trial_sub
// Purpose  : Combinational (WIDTH+1)-bit trial subtraction r' - {0,divisor},
//            formed as r' + ~{0,divisor} + 1 like the ALU subtractor.
// Ports    : r_shift   in  WIDTH+1  shifted partial remainder r'
//            divisor   in  WIDTH    unsigned divisor
//            trial     out WIDTH    low bits of r' - divisor
//            no_borrow out 1        carry out of the subtraction (r' >= divisor)
// Revision : 1.0 - initial release
// ============================================================================
module div_trial_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   r_shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] trial,
  output logic             no_borrow
);

  // Low WIDTH columns of r' + ~{0,d} + 1, with their carry in the top bit.
  logic [WIDTH:0] w_low_sum;

  assign w_low_sum = {1'b0, r_shift[WIDTH-1:0]} + {1'b0, ~divisor} + (WIDTH+1)'(1);
  assign trial     = w_low_sum[WIDTH-1:0];

  // The guard column adds r'[WIDTH] + 1 (inverted zero-extension) + carry, so
  // it carries out whenever either input is set. Its sum bit is the guard bit
  // of the result, which is always zero when the trial is kept, so it is not
  // produced here.
  assign no_borrow = r_shift[WIDTH] | w_low_sum[WIDTH];

endmodule : div_trial_sub
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle unsigned restoring divider, one trial subtraction
//            per clock, behind a start/done handshake.
// Ports    : clk, rst (sync, active high)
//            start, dividend[WIDTH], divisor[WIDTH]  request + operands
//            busy        high while iterating
//            done        one-cycle result-valid pulse
//            quotient, remainder [WIDTH]  held until next accepted start
//            div_by_zero only when DIVZERO_FLAG_EN is defined
// Macro    : DIVZERO_FLAG_EN - zero divisor short-cuts to DONE and raises
//            div_by_zero; otherwise it runs the normal iteration.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIVZERO_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int                CNT_W       = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Partial remainder. Its guard bit is zero after every step, so only the
  // low WIDTH bits are stored; the guard appears in r' as the shifted-out bit.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
`ifdef DIVZERO_FLAG_EN
  logic             dz_q, dz_d;
`endif

  logic [WIDTH:0]   w_r_shift;
  logic [WIDTH-1:0] w_trial;
  logic             w_no_borrow;
  logic [WIDTH-1:0] w_r_step;
  logic [WIDTH-1:0] w_q_step;

  assign w_r_shift = {r_q, q_q[WIDTH-1]};

  div_trial_sub #(
    .WIDTH (WIDTH)
  ) u_trial (
    .r_shift   (w_r_shift),
    .divisor   (dvs_q),
    .trial     (w_trial),
    .no_borrow (w_no_borrow)
  );

  // Restore on borrow; dividend bits shift out of q as quotient bits shift in.
  assign w_r_step = w_no_borrow ? w_trial : w_r_shift[WIDTH-1:0];
  assign w_q_step = {q_q[WIDTH-2:0], w_no_borrow};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIVZERO_FLAG_EN
    dz_d    = dz_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dvs_d   = divisor;
          r_d     = '0;
          q_d     = dividend;
          cnt_d   = '0;
          state_d = RUN;
`ifdef DIVZERO_FLAG_EN
          dz_d    = 1'b0;
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        r_d   = w_r_step;
        q_d   = w_q_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST_ITER) begin
          state_d = DONE;
          // Results are loaded from the final step so they appear with done.
          quot_d  = w_q_step;
          rem_d   = w_r_step;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIVZERO_FLAG_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIVZERO_FLAG_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
`ifdef DIVZERO_FLAG_EN
  assign div_by_zero = dz_q;
`endif

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Self-checking bench for seq_divider at WIDTH=4 (directed and
//            random operations) and WIDTH=8 (free-running random start).
//            A transaction-level model predicts outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

`ifdef DIVZERO_FLAG_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       a_start, a_busy, a_done;
  logic [3:0] a_dvd, a_dvs, a_q, a_r;
  logic       b_start, b_busy, b_done;
  logic [7:0] b_dvd, b_dvs, b_q, b_r;
`ifdef DIVZERO_FLAG_EN
  logic       a_dz, b_dz;
`endif

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(4)) u_dut_a (
    .clk (clk), .rst (rst), .start (a_start), .dividend (a_dvd), .divisor (a_dvs),
    .busy (a_busy), .done (a_done), .quotient (a_q), .remainder (a_r)
`ifdef DIVZERO_FLAG_EN
    , .div_by_zero (a_dz)
`endif
  );

  seq_divider #(.WIDTH(8)) u_dut_b (
    .clk (clk), .rst (rst), .start (b_start), .dividend (b_dvd), .divisor (b_dvs),
    .busy (b_busy), .done (b_done), .quotient (b_q), .remainder (b_r)
`ifdef DIVZERO_FLAG_EN
    , .div_by_zero (b_dz)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted operation yields q = a/b, r = a%b
  // exactly WIDTH cycles later (or at once for a flagged zero divisor).
  typedef struct {
    int rem;  // cycles left before the result appears
    bit done;
    int q, r, pq, pr, adv, ads;
    bit dz;
  } model_t;

  function automatic model_t step(model_t m, int w, bit rs, bit st, int dvd, int dvs);
    model_t n = m;
    n.done = 1'b0;
    if (rs) begin
      n.rem = 0; n.q = 0; n.r = 0; n.dz = 1'b0;
      return n;
    end
    if (m.rem > 0) begin
      n.rem = m.rem - 1;
      if (n.rem == 0) begin
        n.done = 1'b1; n.q = m.pq; n.r = m.pr;
      end
    end else if (st) begin
      n.adv = dvd; n.ads = dvs; n.dz = 1'b0;
      if (dvs == 0) begin n.pq = (1 << w) - 1; n.pr = dvd; end
      else begin n.pq = dvd / dvs; n.pr = dvd % dvs; end
      if (DZ_EN && dvs == 0) begin
        n.done = 1'b1; n.q = n.pq; n.r = n.pr; n.dz = 1'b1;
      end else begin
        n.rem = w;
      end
    end
    return n;
  endfunction

  model_t ma, mb;
  bit     chk_en = 1'b0;
  bit     stop_b = 1'b0;

  always @(posedge clk) begin
    ma <= step(ma, 4, rst, a_start, int'(a_dvd), int'(a_dvs));
    mb <= step(mb, 8, rst, b_start, int'(b_dvd), int'(b_dvs));
  end

  // Single compare process: every cycle, both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_busy", 32'(a_busy), 32'(ma.rem > 0));
      check("a_done", 32'(a_done), 32'(ma.done));
      check("a_quot", 32'(a_q), 32'(ma.q));
      check("a_rem",  32'(a_r), 32'(ma.r));
      check("b_busy", 32'(b_busy), 32'(mb.rem > 0));
      check("b_done", 32'(b_done), 32'(mb.done));
      check("b_quot", 32'(b_q), 32'(mb.q));
      check("b_rem",  32'(b_r), 32'(mb.r));
`ifdef DIVZERO_FLAG_EN
      check("a_dz", 32'(a_dz), 32'(ma.dz));
      check("b_dz", 32'(b_dz), 32'(mb.dz));
`endif
      if (a_done) begin
        check("a_inv", 32'(int'(a_q) * ma.ads + int'(a_r)), 32'(ma.adv));
        check("a_rlt", 32'((int'(a_r) < ma.ads) || (ma.ads == 0)), 32'd1);
      end
      if (b_done) begin
        check("b_inv", 32'(int'(b_q) * mb.ads + int'(b_r)), 32'(mb.adv));
        check("b_rlt", 32'((int'(b_r) < mb.ads) || (mb.ads == 0)), 32'd1);
      end
    end
  end

  // Called at a negedge: pulses start for one cycle, waits for done, and
  // checks latency, busy length and results against literal expectations.
  task automatic do_div(input int dvd, input int dvs, input int exp_lat,
                        input int exp_busy, input int exp_q, input int exp_r,
                        input string tag);
    int cyc = 0;
    int nb  = 0;
    bit got = 1'b0;
    a_start = 1'b1;
    a_dvd   = 4'(dvd);
    a_dvs   = 4'(dvs);
    while (cyc < 20 && !got) begin
      @(negedge clk);
      a_start = 1'b0;
      cyc++;
      if (a_busy) nb++;
      if (a_done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", tag);
    end else begin
      check({tag, "_lat"},  32'(cyc), 32'(exp_lat));
      check({tag, "_busy"}, 32'(nb), 32'(exp_busy));
      check({tag, "_q"},    32'(a_q), 32'(exp_q));
      check({tag, "_r"},    32'(a_r), 32'(exp_r));
    end
  endtask

  // WIDTH=8 DUT: random start every cycle, start often high during RUN.
  initial begin
    b_start = 1'b0;
    b_dvd   = '0;
    b_dvs   = 8'd1;
    while (!stop_b) begin
      @(negedge clk);
      b_start = 1'($urandom_range(0, 1));
      b_dvd   = 8'($urandom_range(0, 255));
      b_dvs   = 8'($urandom_range(1, 255));
    end
  end

  initial begin
    int cyc;
    int ndone;
    bit got;
    rst     = 1'b1;
    a_start = 1'b0;
    a_dvd   = '0;
    a_dvs   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_q",    32'(a_q), 32'd0);
    check("rst_r",    32'(a_r), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div(13, 4, 5, 4, 3, 1, "d13_4");
    do_div(15, 1, 5, 4, 15, 0, "d15_1");
    do_div(7, 9, 5, 4, 0, 7, "d7_9");
    do_div(0, 5, 5, 4, 0, 0, "d0_5");
`ifdef DIVZERO_FLAG_EN
    do_div(9, 0, 1, 0, 15, 9, "d9_0");
    check("dz_set", 32'(a_dz), 32'd1);
    do_div(6, 3, 5, 4, 2, 0, "d6_3");
    check("dz_clr", 32'(a_dz), 32'd0);
`else
    do_div(9, 0, 5, 4, 15, 9, "d9_0");
    do_div(6, 3, 5, 4, 2, 0, "d6_3");
`endif

    // start held through RUN with new operands, then accepted in DONE.
    @(negedge clk);
    a_start = 1'b1; a_dvd = 4'd13; a_dvs = 4'd4;
    @(negedge clk);
    a_dvd = 4'd6; a_dvs = 4'd2;
    cyc = 1; got = 1'b0;
    if (a_done) got = 1'b1;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      cyc++;
      if (a_done) got = 1'b1;
    end
    check("hold_lat", 32'(cyc), 32'd5);
    check("hold_q", 32'(a_q), 32'd3);
    check("hold_r", 32'(a_r), 32'd1);
    @(negedge clk);
    a_start = 1'b0;
    check("b2b_busy", 32'(a_busy), 32'd1);
    cyc = 1; got = 1'b0;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      cyc++;
      if (a_done) got = 1'b1;
    end
    check("b2b_lat", 32'(cyc), 32'd5);
    check("b2b_q", 32'(a_q), 32'd3);
    check("b2b_r", 32'(a_r), 32'd0);

    // Reset two cycles into a 14/3 operation aborts it.
    @(negedge clk);
    a_start = 1'b1; a_dvd = 4'd14; a_dvs = 4'd3;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_done", 32'(a_done), 32'd0);
    check("abort_q", 32'(a_q), 32'd0);
    check("abort_r", 32'(a_r), 32'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_done) ndone++;
    end
    check("abort_nodone", 32'(ndone), 32'd0);
    do_div(14, 3, 5, 4, 4, 2, "d14_3");

    // Random operations on the WIDTH=4 DUT, nonzero divisors.
    repeat (150) begin
      int dvd, dvs;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      dvd = int'($urandom_range(0, 15));
      dvs = int'($urandom_range(1, 15));
      do_div(dvd, dvs, 5, 4, dvd / dvs, dvd % dvs, "rnd");
    end

    stop_b = 1'b1;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_divider
`default_nettype wire
